// File: rtl/regfile_dump.sv
// regfile_dump: walks a register address range over one regfile read port and streams each value out
module regfile_dump #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] last;
    logic          free, hs, at_last;

    assign hs      = out_valid && out_ready;
    assign free    = !out_valid || out_ready;
    assign at_last = ra == last;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: READ leaves once the final address is captured, DRAIN once it is accepted
    always_comb begin
        state_nxt = (state == IDLE && start)          ? READ  :
                    (state == READ && free && at_last) ? DRAIN :
                    (state == DRAIN && hs)             ? IDLE  : state;
    end

    // state-derived outputs
    always_comb begin
        busy = state != IDLE;
    end

    // read pointer, range latch and output word register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra        <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= state == DRAIN && hs;
            if (state == IDLE && start) begin
                ra   <= first_addr;
                last <= last_addr;
            end
            if (state == READ && free) begin
                out_data  <= rd;
                out_addr  <= ra;
                out_valid <= 1'b1;
                out_last  <= at_last;
                if (!at_last) ra <= ra + AW'(1);
            end
            if (state == DRAIN && hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized dumps against a behavioural regfile and range model
module tb_regfile_dump;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset, start, out_ready, out_valid, out_last, busy, done;
    logic [AW-1:0] first_addr, last_addr, ra, out_addr;
    logic [DW-1:0] rd, out_data;
    logic [DW-1:0] regs [32];

    int n_pass = 0;
    int n_checks = 0;

    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int   n_done, unstable, stalls, valid_cycles, first_hs, last_hs, done_gap;
    logic timeout;

    always #5 clk = ~clk;

    assign rd = regs[ra];

    regfile_dump #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a != 0) regs[a] = d;
    endtask

    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(posedge clk); #1;
        start = 1'b0;
        first_addr = AW'($urandom);
        last_addr = AW'($urandom);
    endtask

    task automatic collect(input int stall_pct, input int hold, input int budget);
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        logic hl, held;
        got_addr.delete(); got_data.delete(); got_last.delete();
        n_done = 0; unstable = 0; stalls = 0; valid_cycles = 0;
        first_hs = -1; last_hs = -1; done_gap = -1; timeout = 1'b1; held = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (out_valid && hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else out_ready = $urandom_range(99) >= stall_pct;
            if (held && {out_valid, out_data, out_addr, out_last} !== {1'b1, hd, ha, hl}) unstable++;
            held = out_valid && !out_ready;
            hd = out_data; ha = out_addr; hl = out_last;
            if (out_valid) valid_cycles++;
            if (held) stalls++;
            if (out_valid && out_ready) begin
                got_addr.push_back(out_addr);
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                done_gap = c - last_hs;
                timeout = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        n_checks++; if (ra !== 0) $display("FAIL reset_ra: got %h want 0", ra); else n_pass++;
        n_checks++; if (out_valid !== 0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_addr !== 0) $display("FAIL reset_addr: got %h want 0", out_addr); else n_pass++;
        n_checks++; if (out_last !== 0) $display("FAIL reset_last: got %b want 0", out_last); else n_pass++;
        n_checks++; if (busy !== 0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full;
        wr(1, 32'hAAAA_BBBB);
        wr(2, 32'hBBBB_AAAA);
        wr(0, 32'h1111_2222);
        for (int i = 3; i < 32; i++) wr(AW'(i), $urandom);
        do_start(0, 31);
        collect(0, 0, 100);
        n_checks++; if (timeout !== 0) $display("FAIL full_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got_addr.size() != 32) $display("FAIL full_count: got %0d want 32", got_addr.size()); else n_pass++;
        for (int i = 0; i < got_addr.size(); i++) begin
            n_checks++; if (got_addr[i] !== AW'(i)) $display("FAIL full_addr[%0d]: got %0d want %0d", i, got_addr[i], i); else n_pass++;
            n_checks++; if (got_data[i] !== regs[i]) $display("FAIL full_data[%0d]: got %h want %h", i, got_data[i], regs[i]); else n_pass++;
            n_checks++; if (got_last[i] !== (i == 31)) $display("FAIL full_last[%0d]: got %b want %b", i, got_last[i], i == 31); else n_pass++;
        end
        if (got_data.size() >= 3) begin
            n_checks++; if (got_data[0] !== 32'h0) $display("FAIL full_reg0: got %h want 0", got_data[0]); else n_pass++;
            n_checks++; if (got_data[1] !== 32'hAAAA_BBBB) $display("FAIL full_reg1: got %h want aaaabbbb", got_data[1]); else n_pass++;
            n_checks++; if (got_data[2] !== 32'hBBBB_AAAA) $display("FAIL full_reg2: got %h want bbbbaaaa", got_data[2]); else n_pass++;
        end
        n_checks++; if (first_hs !== 1) $display("FAIL full_latency: got %0d want 1", first_hs); else n_pass++;
        n_checks++; if (valid_cycles !== 32) $display("FAIL full_valid_cycles: got %0d want 32", valid_cycles); else n_pass++;
        n_checks++; if (done_gap !== 0) $display("FAIL full_done_gap: got %0d want 0", done_gap); else n_pass++;
        n_checks++; if (busy !== 0) $display("FAIL full_busy_at_done: got %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done !== 0) $display("FAIL full_done_pulse: got %b want 0", done); else n_pass++;
        n_checks++; if (out_valid !== 0) $display("FAIL full_extra_beat: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure;
        do_start(1, 2);
        collect(0, 3, 50);
        n_checks++; if (timeout !== 0) $display("FAIL bp_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got_addr.size() != 2) $display("FAIL bp_count: got %0d want 2", got_addr.size()); else n_pass++;
        if (got_addr.size() == 2) begin
            n_checks++; if ({got_addr[0], got_data[0], got_last[0]} !== {5'd1, 32'hAAAA_BBBB, 1'b0})
                $display("FAIL bp_word0: got %0d/%h/%b want 1/aaaabbbb/0", got_addr[0], got_data[0], got_last[0]); else n_pass++;
            n_checks++; if ({got_addr[1], got_data[1], got_last[1]} !== {5'd2, 32'hBBBB_AAAA, 1'b1})
                $display("FAIL bp_word1: got %0d/%h/%b want 2/bbbbaaaa/1", got_addr[1], got_data[1], got_last[1]); else n_pass++;
        end
        n_checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (stalls !== 3) $display("FAIL bp_stalls: got %0d want 3", stalls); else n_pass++;
        n_checks++; if (valid_cycles !== 5) $display("FAIL bp_valid_cycles: got %0d want 5", valid_cycles); else n_pass++;
        n_checks++; if (first_hs !== 4) $display("FAIL bp_first_hs: got %0d want 4", first_hs); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [AW-1:0] want [4];
        want[0] = 30; want[1] = 31; want[2] = 0; want[3] = 1;
        do_start(30, 1);
        collect(30, 0, 100);
        n_checks++; if (timeout !== 0) $display("FAIL wrap_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got_addr.size() != 4) $display("FAIL wrap_count: got %0d want 4", got_addr.size()); else n_pass++;
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            n_checks++; if (got_addr[i] !== want[i]) $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, got_addr[i], want[i]); else n_pass++;
            n_checks++; if (got_data[i] !== regs[want[i]]) $display("FAIL wrap_data[%0d]: got %h want %h", i, got_data[i], regs[want[i]]); else n_pass++;
            n_checks++; if (got_last[i] !== (i == 3)) $display("FAIL wrap_last[%0d]: got %b want %b", i, got_last[i], i == 3); else n_pass++;
        end
        n_checks++; if (unstable !== 0) $display("FAIL wrap_stable: got %0d changes want 0", unstable); else n_pass++;
        n_checks++; if (valid_cycles !== 4 + stalls) $display("FAIL wrap_valid_cycles: got %0d want %0d", valid_cycles, 4 + stalls); else n_pass++;
    endtask

    task automatic test_single;
        int extra = 0;
        do_start(5, 5);
        n_checks++; if (busy !== 1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        start = 1'b1; first_addr = 0; last_addr = 31;
        @(posedge clk); #1;
        start = 1'b0;
        collect(0, 0, 50);
        n_checks++; if (timeout !== 0) $display("FAIL single_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got_addr.size() != 1) $display("FAIL single_count: got %0d want 1", got_addr.size()); else n_pass++;
        if (got_addr.size() == 1) begin
            n_checks++; if ({got_addr[0], got_data[0], got_last[0]} !== {5'd5, regs[5], 1'b1})
                $display("FAIL single_word: got %0d/%h/%b want 5/%h/1", got_addr[0], got_data[0], got_last[0], regs[5]); else n_pass++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy || done) extra++;
        end
        out_ready = 1'b0;
        n_checks++; if (extra !== 0) $display("FAIL single_ignored_start: got %0d active cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++) begin
            logic [AW-1:0] f, l;
            int n;
            f = AW'($urandom);
            l = AW'($urandom);
            n = ((int'(l) - int'(f)) & 31) + 1;
            do_start(f, l);
            collect(40, 0, 400);
            n_checks++; if (timeout !== 0) $display("FAIL rand%0d_timeout: got no done want done", t); else n_pass++;
            n_checks++; if (got_addr.size() != n) $display("FAIL rand%0d_count: got %0d want %0d", t, got_addr.size(), n); else n_pass++;
            for (int i = 0; i < got_addr.size() && i < n; i++) begin
                logic [AW-1:0] a;
                a = AW'(int'(f) + i);
                n_checks++; if ({got_addr[i], got_data[i], got_last[i]} !== {a, regs[a], i == n - 1})
                    $display("FAIL rand%0d_word[%0d]: got %0d/%h/%b want %0d/%h/%b", t, i, got_addr[i], got_data[i], got_last[i], a, regs[a], i == n - 1); else n_pass++;
            end
            n_checks++; if (unstable !== 0) $display("FAIL rand%0d_stable: got %0d changes want 0", t, unstable); else n_pass++;
            n_checks++; if (valid_cycles !== n + stalls) $display("FAIL rand%0d_valid_cycles: got %0d want %0d", t, valid_cycles, n + stalls); else n_pass++;
            n_checks++; if (done_gap !== 0) $display("FAIL rand%0d_done_gap: got %0d want 0", t, done_gap); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int beats = 0;
        int extra = 0;
        do_start(0, 31);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            if (out_valid && out_ready) beats++;
            @(posedge clk); #1;
        end
        n_checks++; if (beats !== 3) $display("FAIL mid_beats_before_reset: got %0d want 3", beats); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({out_valid, busy, done, ra} !== '0)
            $display("FAIL mid_async_reset: got valid=%b busy=%b done=%b ra=%0d want all 0", out_valid, busy, done, ra); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL mid_after_reset: got %0d active cycles want 0", extra); else n_pass++;
        do_start(0, 0);
        collect(0, 0, 20);
        n_checks++; if (timeout !== 0) $display("FAIL mid_restart_timeout: got no done want done"); else n_pass++;
        n_checks++; if (got_addr.size() != 1) $display("FAIL mid_restart_count: got %0d want 1", got_addr.size()); else n_pass++;
        if (got_addr.size() == 1) begin
            n_checks++; if ({got_addr[0], got_data[0], got_last[0]} !== {5'd0, 32'h0, 1'b1})
                $display("FAIL mid_restart_word: got %0d/%h/%b want 0/0/1", got_addr[0], got_data[0], got_last[0]); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        start = 1'b0;
        out_ready = 1'b0;
        first_addr = '0;
        last_addr = '0;
        test_reset;
        test_full;
        test_backpressure;
        test_wrap;
        test_single;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
